// File: rtl/mem_march_initiator_pkg.sv
// Shared types and the march data pattern for the memory march initiator.
package mem_march_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } march_state_e;

  // Pattern arithmetic is done at this width; callers keep the low DATA_WIDTH
  // bits, which gives the modulo-2**DATA_WIDTH wrap for free.
  localparam int PAT_MAX_W = 64;

  // P0(a) = seed + a, P1(a) = ~P0(a)
  function automatic logic [PAT_MAX_W-1:0] march_pattern(
    input logic [PAT_MAX_W-1:0] seed,
    input logic [PAT_MAX_W-1:0] addr,
    input logic                 pass_idx
  );
    logic [PAT_MAX_W-1:0] p0;
    p0 = seed + addr;
    return pass_idx ? ~p0 : p0;
  endfunction

endpackage

// File: rtl/mem_march_initiator_if.sv
// Single-port memory bus between the march initiator and the memory.
interface mem_march_initiator_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output addr, wr_en, rd_en, wdata, input rdata);
  modport slave  (input addr, wr_en, rd_en, wdata, output rdata);
endinterface

// File: rtl/mem_march_initiator_rd_checker.sv
// Read-data checker: 1-deep expected-value pipeline, saturating error count
// and first-failure capture.
module mem_rd_checker #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ERR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  cmp_valid,
  input  logic [ADDR_WIDTH-1:0] cmp_addr,
  input  logic                  cmp_pass,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  mismatch,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  fail_pass
);

  logic                  vld_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  pass_q;
  logic                  seen;

  // rdata belongs to the read issued one cycle earlier
  assign mismatch = vld_q && (rdata != exp_q);

  // Track the in-flight read, count mismatches, keep only the first failure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q     <= 1'b0;
      exp_q     <= '0;
      addr_q    <= '0;
      pass_q    <= 1'b0;
      seen      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_pass <= 1'b0;
    end else if (clear) begin
      vld_q     <= 1'b0;
      seen      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_pass <= 1'b0;
    end else begin
      vld_q  <= cmp_valid;
      exp_q  <= exp_data;
      addr_q <= cmp_addr;
      pass_q <= cmp_pass;
      if (mismatch) begin
        if (err_count != {ERR_WIDTH{1'b1}}) err_count <= err_count + 1'b1;
        if (!seen) begin
          seen      <= 1'b1;
          fail_addr <= addr_q;
          fail_pass <= pass_q;
        end
      end
    end
  end

endmodule

// File: rtl/mem_march_initiator.sv
// Two-pass write/read-compare march over a single-port memory.
// Pass 0 writes seed+a, pass 1 writes its complement; each pass reads back
// every address and one drain cycle lets the last read land.
module mem_march_initiator
  import mem_march_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ERR_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  seed,
  mem_march_initiator_if.master  mem,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_WIDTH-1:0]   err_count,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic                   fail_pass
);

  localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

  march_state_e          state;
  logic                  pass_idx;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  accept;
  logic                  mismatch;

  function automatic logic [DATA_WIDTH-1:0] pat(
    input logic [DATA_WIDTH-1:0] s,
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  p
  );
    logic [PAT_MAX_W-1:0] t;
    t = march_pattern(PAT_MAX_W'(s), PAT_MAX_W'(a), p);
    return t[DATA_WIDTH-1:0];
  endfunction

  assign accept = start && (state == S_IDLE || state == S_DONE);

  // Sequencer: the bus registers hold the operation of the current cycle,
  // and mem.addr doubles as the address counter (it is 0 between phases).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pass_idx  <= 1'b0;
      seed_q    <= '0;
      mem.addr  <= '0;
      mem.wr_en <= 1'b0;
      mem.rd_en <= 1'b0;
      mem.wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (accept) begin
          state     <= S_WRITE;
          pass_idx  <= 1'b0;
          seed_q    <= seed;
          mem.addr  <= '0;
          mem.wr_en <= 1'b1;
          mem.wdata <= pat(seed, '0, 1'b0);
          busy      <= 1'b1;
          done      <= 1'b0;
          pass      <= 1'b0;
        end
        S_WRITE: if (mem.addr == LAST) begin
          state     <= S_READ;
          mem.addr  <= '0;
          mem.wr_en <= 1'b0;
          mem.rd_en <= 1'b1;
          mem.wdata <= '0;
        end else begin
          mem.addr  <= mem.addr + 1'b1;
          mem.wdata <= pat(seed_q, mem.addr + 1'b1, pass_idx);
        end
        S_READ: if (mem.addr == LAST) begin
          state     <= S_DRAIN;
          mem.addr  <= '0;
          mem.rd_en <= 1'b0;
        end else begin
          mem.addr  <= mem.addr + 1'b1;
        end
        S_DRAIN: if (!pass_idx) begin
          state     <= S_WRITE;
          pass_idx  <= 1'b1;
          mem.addr  <= '0;
          mem.wr_en <= 1'b1;
          mem.wdata <= pat(seed_q, '0, 1'b1);
        end else begin
          // last compare resolves on this same edge, so fold it in here
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == '0) && !mismatch;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mem_rd_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ERR_WIDTH  (ERR_WIDTH)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .cmp_valid (mem.rd_en),
    .cmp_addr  (mem.addr),
    .cmp_pass  (pass_idx),
    .exp_data  (pat(seed_q, mem.addr, pass_idx)),
    .rdata     (mem.rdata),
    .mismatch  (mismatch),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_pass (fail_pass)
  );

endmodule

// File: tb/tb_mem_march_initiator.sv
// Bench: behavioural memory with fault injection, write scoreboard, result checks.
module tb_mem_march_initiator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       busy, done, pass, fail_pass;
  logic [3:0] err_count;
  logic [1:0] fail_addr;
  logic       busy2, done2, pass2, fail_pass2;
  logic [1:0] err_count2;
  logic [1:0] fail_addr2;

  int n_tests = 0;
  int n_fail  = 0;
  int fault   = 0;

  typedef struct { logic [1:0] a; logic [7:0] d; } wr_t;
  wr_t wq[$];

  mem_march_initiator_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) m ();
  mem_march_initiator_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) m2 ();

  always #5 clk = ~clk;

  mem_march_initiator #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .ERR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .mem(m),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_pass(fail_pass)
  );

  // second instance sees rdata stuck at 0 and a 2-bit error counter
  mem_march_initiator #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .ERR_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .mem(m2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .fail_addr(fail_addr2), .fail_pass(fail_pass2)
  );

  assign m2.rdata = 8'h00;

  // memory model, 1-cycle read latency; fault 1 = bit0 stuck-at-0 at address 2
  logic [7:0] mem [4];
  always @(posedge clk) begin
    if (m.wr_en) mem[m.addr] <= m.wdata;
    if (m.rd_en) m.rdata <= (fault == 1 && m.addr == 2'd2) ? (mem[m.addr] & 8'hFE) : mem[m.addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [7:0] s, input int a, input bit p);
    logic [7:0] v;
    v = s + 8'(a);
    return p ? ~v : v;
  endfunction

  task automatic run(input logic [7:0] sd, input int flt, input bit pulse,
                     input bit exp_pass, input int exp_err, input int exp_fa, input int exp_fp);
    wr_t e;
    int  done_cyc;
    fault = flt;
    wq.delete();
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 4; a++) wq.push_back('{a: 2'(a), d: pat(sd, a, p[0])});
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clk);
      chk("excl", 64'(m.wr_en & m.rd_en), 0);
      chk("wr_en", 64'(m.wr_en), 64'((cyc >= 1 && cyc <= 4) || (cyc >= 10 && cyc <= 13)));
      chk("rd_en", 64'(m.rd_en), 64'((cyc >= 5 && cyc <= 8) || (cyc >= 14 && cyc <= 17)));
      if (m.wr_en) begin
        if (wq.size() == 0) chk("wq_underflow", 1, 0);
        else begin
          e = wq.pop_front();
          chk("waddr", 64'(m.addr), 64'(e.a));
          chk("wdata", 64'(m.wdata), 64'(e.d));
        end
      end else if (!m.rd_en) begin
        chk("idle_addr", 64'(m.addr), 0);
        chk("idle_wdata", 64'(m.wdata), 0);
      end
      chk("busy", 64'(busy), 64'(cyc < 19));
      chk("done", 64'(done), 64'(cyc >= 19));
      if (done && done_cyc == 0) done_cyc = cyc;
      start = pulse && (cyc == 3 || cyc == 10);
    end
    start = 1'b0;
    chk("done_cyc", 64'(done_cyc), 19);
    chk("wq_empty", 64'(wq.size()), 0);
    chk("pass", 64'(pass), 64'(exp_pass));
    chk("err_count", 64'(err_count), 64'(exp_err));
    chk("fail_addr", 64'(fail_addr), 64'(exp_fa));
    chk("fail_pass", 64'(fail_pass), 64'(exp_fp));
  endtask

  initial begin
    // reset state, with a start that must be ignored while in reset
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_pass", 64'(pass), 0);
    chk("rst_err", 64'(err_count), 0);
    chk("rst_bus", 64'({m.wr_en, m.rd_en, m.addr, m.wdata}), 0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_start_ignored", 64'(busy), 0);

    // healthy memory
    run(8'h10, 0, 1'b0, 1'b1, 0, 0, 0);
    // rdata stuck at 0 on the 2-bit-counter instance
    chk("sat_done", 64'(done2), 1);
    chk("sat_err", 64'(err_count2), 3);
    chk("sat_fail_addr", 64'(fail_addr2), 0);
    chk("sat_fail_pass", 64'(fail_pass2), 0);
    chk("sat_pass", 64'(pass2), 0);

    // stuck-at-0 on bit0 at address 2 (restart from DONE)
    run(8'h10, 1, 1'b0, 1'b0, 1, 2, 1);
    // wrap-around seed, with stray start pulses mid-run
    run(8'hFE, 0, 1'b1, 1'b1, 0, 0, 0);

    // reset during READ of pass 0
    fault = 0;
    @(negedge clk);
    seed  = 8'h10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_rd_en", 64'(m.rd_en), 1);
    reset = 1'b0;
    #1;
    chk("async_busy", 64'(busy), 0);
    chk("async_bus", 64'({m.wr_en, m.rd_en, m.addr, m.wdata}), 0);
    chk("async_res", 64'({done, pass, err_count, fail_addr, fail_pass}), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_idle", 64'({busy, done, m.wr_en, m.rd_en}), 0);
    run(8'h10, 0, 1'b0, 1'b1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_march_initiator.md
# mem_march_initiator

Self-contained initiator that drives the single-port memory's `addr`/`wr_en`/`rd_en`/`wdata` bus and checks `rdata`. It runs a two-pass write/read-compare march over every address and reports pass/fail. It sits opposite the memory, on the side normally occupied by the verification driver, so the same memory can be exercised in-system without a bench.

## Interface
- `ADDR_WIDTH`, default 2: memory address width; DEPTH = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 8: memory data width.
- `ERR_WIDTH`, default 4: width of the saturating mismatch counter.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset; 0 = in reset.
- `start` input 1: one-cycle request to begin a run.
- `seed` input DATA_WIDTH: base pattern; sampled when `start` is accepted.
- `addr` output ADDR_WIDTH: memory address.
- `wr_en` output 1: memory write strobe.
- `rd_en` output 1: memory read strobe.
- `wdata` output DATA_WIDTH: memory write data.
- `rdata` input DATA_WIDTH: memory read data, valid one cycle after `rd_en`.
- `busy` output 1: run in progress.
- `done` output 1: run finished; held until the next accepted `start`.
- `pass` output 1: valid while `done`=1; 1 when `err_count`=0.
- `err_count` output ERR_WIDTH: mismatches this run, saturating at all-ones.
- `fail_addr` output ADDR_WIDTH: address of the first mismatch.
- `fail_pass` output 1: pass index (0/1) of the first mismatch.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE; a `pass_idx` bit (0/1) tracks the pass.
- Pattern: P0(a) = seed + a, modulo 2**DATA_WIDTH. P1(a) = ~P0(a). `seed` is latched on start.
- IDLE/DONE + `start`=1:
  - Clear `err_count`, `fail_*` and `done`.
  - Set `pass_idx`=0, address counter = 0.
  - Go to WRITE. `start` is ignored in every other state.
- WRITE: each cycle, `wr_en`=1, `addr`=a, `wdata`=Ppass(a), then a++. After a=DEPTH-1, reset a to 0 and go to READ.
- READ: each cycle, `rd_en`=1, `addr`=a. The expected value and address are registered into a 1-deep compare pipeline. After a=DEPTH-1, go to DRAIN.
- DRAIN: one cycle with no strobes; the last read is compared. Then:
  - if `pass_idx`=0: set `pass_idx`=1, a=0, go to WRITE;
  - otherwise go to DONE.
- Compare: in the cycle after each read, `rdata` is compared with the expected value. On a mismatch:
  - `err_count` increments, saturating.
  - If this is the first mismatch of the run, `fail_addr` and `fail_pass` are captured.
- DONE: `done`=1, `busy`=0, `pass`=(`err_count`==0).
- `wr_en` and `rd_en` are never high together. `addr`/`wdata` are 0 when no strobe is active.
- `reset` low (any state, including mid-run): state goes to IDLE and every output goes to 0 immediately (asynchronous). No partial result is kept.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Edge E0 samples `start`=1.
- The first write is visible after E0, during cycle 1. `busy` rises in the same cycle.
- Per pass: DEPTH write cycles, then DEPTH read cycles, then 1 drain cycle.
- `done` rises in cycle 4·DEPTH+3 after E0. For DEPTH=4 this is cycle 19.
- Read latency is fixed at 1 cycle; `rdata` is sampled at the edge ending the cycle after `rd_en`.
- `start` coincident with `reset` low: ignored.

## Structure
- Package `mem_march_pkg` holds:
  - the state enum `march_state_e`;
  - a function `march_pattern(seed, addr, pass_idx)` returning DATA_WIDTH bits.
- One sub-module is natural: `mem_rd_checker`, containing:
  - the expected/address compare pipeline;
  - the saturating `err_count`;
  - the first-fail capture.
  It has a `clear` input and a `cmp_valid` input.

## Test plan
- Healthy memory, DEPTH=4, `seed`=8'h10:
  - writes 10,11,12,13, then EF,EE,ED,EC;
  - `done` at cycle 19, `pass`=1, `err_count`=0.
- Stuck-at-0 on bit0 at address 2:
  - pass 0 reads 12 and is OK; pass 1 expects ED and reads EC;
  - `err_count`=1, `fail_addr`=2, `fail_pass`=1, `pass`=0.
- `seed`=8'hFE, healthy memory:
  - pass-0 `wdata` = FE,FF,00,01 (wrap-around); pass-1 `wdata` = 01,00,FF,FE;
  - `pass`=1.
- `rdata` stuck at 0, `ERR_WIDTH`=2:
  - 8 mismatches occur; `err_count` saturates at 3;
  - `fail_addr`=0, `fail_pass`=0.
- `reset` low for 1 cycle during READ of pass 0:
  - all outputs 0 asynchronously, state IDLE;
  - a following `start` runs the full 19 cycles with `pass`=1.
- `start` pulsed at cycles 3 and 10 of a run: ignored, and the run timing is unchanged. A `start` while in DONE restarts the run and clears `done`.
